// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI-style bus arbiter and device models.
package pci_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  localparam logic [3:0] PCI_CMD_READ  = 4'b0000;
  localparam logic [3:0] PCI_CMD_WRITE = 4'b1000;

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// Request/grant and observed bus-phase signals between the arbiter and the devices.
interface pci_bus_arbiter_if #(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_DEV)
);
  logic [NUM_DEV-1:0] request;
  logic [NUM_DEV-1:0] grant;
  logic               iframe;
  logic               iready;
  logic [IDX_W-1:0]   owner;
  logic               owner_valid;
  logic               bus_idle;
  logic               timeout;

  modport master (
    input  request, iframe, iready,
    output grant, owner, owner_valid, bus_idle, timeout
  );

  modport slave (
    output request, iframe, iready,
    input  grant, owner, owner_valid, bus_idle, timeout
  );
endinterface

// File: rtl/pci_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1, with wrap.
module rr_picker #(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner  = ptr;
    idx     = '0;
    any_req = |req;
    // Walk from farthest to nearest so the nearest requester is the last write.
    for (int i = NUM_DEV; i >= 1; i--) begin
      idx = IDX_W'((int'(ptr) + i) % NUM_DEV);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin central arbiter for the shared PCI-style bus; no preemption mid-transaction.
// Optional grant-inactivity timeout is compiled in with `define ARB_TIMEOUT_EN.
module pci_bus_arbiter
  import pci_pkg::*;
#(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_DEV),
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  pci_bus_arbiter_if.master bus
);

  localparam logic [1:0] StIdle  = IDLE;
  localparam logic [1:0] StGrant = GRANT;
  localparam logic [1:0] StBusy  = BUSY;
  localparam logic [1:0] StTurn  = TURN;

  localparam logic [NUM_DEV-1:0] GntNone = '1;
  localparam logic [IDX_W-1:0]   PtrRst  = IDX_W'(NUM_DEV - 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_DEV-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               timeout_q, timeout_d;
  logic [IDX_W-1:0]   pick;
  logic               any_req;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT;
`endif

  rr_picker #(
    .NUM_DEV (NUM_DEV),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (~bus.request),
    .ptr     (rr_ptr_q),
    .winner  (pick),
    .any_req (any_req)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d  = ~(NUM_DEV'(1) << pick);
          owner_d  = pick;
          rr_ptr_d = pick;
          state_d  = StGrant;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      StGrant: begin
        // iframe takes priority over a same-cycle request withdrawal.
        if (!bus.iframe) begin
          state_d = StBusy;
        end else if (bus.request[owner_q]) begin
          grant_d = GntNone;
          state_d = StTurn;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          grant_d   = GntNone;
          timeout_d = 1'b1;
          state_d   = StTurn;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StBusy: begin
        if (bus.iframe && bus.iready) begin
          grant_d = GntNone;
          state_d = StTurn;
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        grant_d = GntNone;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= GntNone;
      owner_q   <= '0;
      rr_ptr_q  <= PtrRst;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.grant       = grant_q;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = ~&grant_q;
  assign bus.bus_idle    = (state_q == StIdle);
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed, table-driven bench for pci_bus_arbiter plus hand-written multi-cycle sequences.
module tb_pci_bus_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   inv_on;

  pci_bus_arbiter_if #(.NUM_DEV(4), .IDX_W(2)) bus ();

  pci_bus_arbiter #(
    .NUM_DEV (4),
    .IDX_W   (2),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       f;
    logic       r;
    logic [3:0] g;
    logic [1:0] own;
    logic       val;
    logic       idle;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic f, input logic r);
    bus.request = req;
    bus.iframe  = f;
    bus.iready  = r;
  endtask

  // Bus invariants checked every cycle while out of reset.
  always @(negedge clk) begin
    if (inv_on && rst_n) begin
      chk("one_cold", 32'($countones(~bus.grant) <= 1), 32'd1);
      chk("owner_valid_inv", 32'(bus.owner_valid), 32'(~&bus.grant));
    end
  end

  initial begin
    int  n;
    bit  seen_to;
    checks = 0;
    errors = 0;
    inv_on = 1'b0;
    rst_n  = 1'b0;
    drive(4'b1111, 1'b1, 1'b1);

    //         req      f  r   grant    own val idle
    vq.push_back('{4'b1110, 1, 1, 4'b1110, 0, 1, 0});
    vq.push_back('{4'b1110, 0, 1, 4'b1110, 0, 1, 0});
    vq.push_back('{4'b1110, 0, 0, 4'b1110, 0, 1, 0});
    vq.push_back('{4'b1110, 0, 0, 4'b1110, 0, 1, 0});
    vq.push_back('{4'b1111, 1, 1, 4'b1111, 0, 0, 0});
    vq.push_back('{4'b1111, 1, 1, 4'b1111, 0, 0, 1});
    vq.push_back('{4'b0000, 1, 1, 4'b1101, 1, 1, 0});
    vq.push_back('{4'b0000, 0, 0, 4'b1101, 1, 1, 0});
    vq.push_back('{4'b0000, 1, 0, 4'b1101, 1, 1, 0});
    vq.push_back('{4'b0000, 1, 1, 4'b1111, 1, 0, 0});
    vq.push_back('{4'b0000, 1, 1, 4'b1111, 1, 0, 1});
    vq.push_back('{4'b0000, 1, 1, 4'b1011, 2, 1, 0});
    vq.push_back('{4'b0000, 0, 0, 4'b1011, 2, 1, 0});
    vq.push_back('{4'b0000, 1, 1, 4'b1111, 2, 0, 0});
    vq.push_back('{4'b0000, 1, 1, 4'b1111, 2, 0, 1});
    vq.push_back('{4'b0000, 1, 1, 4'b0111, 3, 1, 0});
    vq.push_back('{4'b0000, 0, 0, 4'b0111, 3, 1, 0});
    vq.push_back('{4'b0000, 1, 1, 4'b1111, 3, 0, 0});
    vq.push_back('{4'b0000, 1, 1, 4'b1111, 3, 0, 1});
    vq.push_back('{4'b0000, 1, 1, 4'b1110, 0, 1, 0});
    vq.push_back('{4'b0000, 0, 1, 4'b1110, 0, 1, 0});
    vq.push_back('{4'b0011, 1, 1, 4'b1111, 0, 0, 0});
    vq.push_back('{4'b0011, 1, 1, 4'b1111, 0, 0, 1});
    vq.push_back('{4'b0011, 1, 1, 4'b1011, 2, 1, 0});
    vq.push_back('{4'b0110, 1, 1, 4'b1111, 2, 0, 0});
    vq.push_back('{4'b0110, 1, 1, 4'b1111, 2, 0, 1});
    vq.push_back('{4'b0110, 1, 1, 4'b0111, 3, 1, 0});
    vq.push_back('{4'b0110, 0, 1, 4'b0111, 3, 1, 0});
    vq.push_back('{4'b1111, 0, 0, 4'b0111, 3, 1, 0});
    vq.push_back('{4'b1111, 1, 0, 4'b0111, 3, 1, 0});
    vq.push_back('{4'b1111, 0, 1, 4'b0111, 3, 1, 0});
    vq.push_back('{4'b1111, 1, 1, 4'b1111, 3, 0, 0});
    vq.push_back('{4'b1111, 1, 1, 4'b1111, 3, 0, 1});
    vq.push_back('{4'b1101, 1, 1, 4'b1101, 1, 1, 0});
    vq.push_back('{4'b1111, 0, 1, 4'b1101, 1, 1, 0});
    vq.push_back('{4'b1111, 1, 1, 4'b1111, 1, 0, 0});
    vq.push_back('{4'b1111, 1, 1, 4'b1111, 1, 0, 1});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    inv_on = 1'b1;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'hf);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_valid", 32'(bus.owner_valid), 32'h0);
    chk("rst_idle", 32'(bus.bus_idle), 32'h1);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);

    foreach (vq[i]) begin
      drive(vq[i].req, vq[i].f, vq[i].r);
      step();
      chk($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(vq[i].g));
      chk($sformatf("v%0d_owner", i), 32'(bus.owner), 32'(vq[i].own));
      chk($sformatf("v%0d_valid", i), 32'(bus.owner_valid), 32'(vq[i].val));
      chk($sformatf("v%0d_idle", i), 32'(bus.bus_idle), 32'(vq[i].idle));
      chk($sformatf("v%0d_timeout", i), 32'(bus.timeout), 32'h0);
    end

    // Granted device never drives iframe.
    drive(4'b1110, 1'b1, 1'b1);
    step();
    chk("to_first_grant", 32'(bus.grant), 32'he);
`ifdef ARB_TIMEOUT_EN
    n = 200;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bus.grant == 4'b1111) begin
        n = k;
        break;
      end
      chk("to_early_pulse", 32'(bus.timeout), 32'h0);
    end
    chk("to_grant_cycles", 32'(n), 32'd16);
    chk("to_pulse", 32'(bus.timeout), 32'h1);
    step();
    chk("to_pulse_end", 32'(bus.timeout), 32'h0);
    chk("to_turn_idle", 32'(bus.bus_idle), 32'h1);
    step();
    chk("to_regrant", 32'(bus.grant), 32'he);
`else
    seen_to = 1'b0;
    repeat (110) begin
      step();
      if (bus.timeout) seen_to = 1'b1;
    end
    chk("noto_grant_held", 32'(bus.grant), 32'he);
    chk("noto_no_pulse", 32'(seen_to), 32'h0);
`endif
    drive(4'b1111, 1'b1, 1'b1);
    step();
    chk("to_release", 32'(bus.grant), 32'hf);
    step();
    chk("to_back_idle", 32'(bus.bus_idle), 32'h1);

    // Asynchronous reset in the middle of a transaction.
    drive(4'b1101, 1'b1, 1'b1);
    step();
    chk("ar_grant", 32'(bus.grant), 32'hd);
    drive(4'b1101, 1'b0, 1'b0);
    step();
    chk("ar_busy", 32'(bus.grant), 32'hd);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_grant_drop", 32'(bus.grant), 32'hf);
    chk("ar_valid_drop", 32'(bus.owner_valid), 32'h0);
    chk("ar_idle", 32'(bus.bus_idle), 32'h1);
    chk("ar_owner", 32'(bus.owner), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 1'b1, 1'b1);
    step();
    chk("ar_dev0_first", 32'(bus.grant), 32'he);
    chk("ar_owner0", 32'(bus.owner), 32'h0);

    inv_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
